// File: rtl/conv_frame_ctrl_if.sv
// Handshake and bus bundle between the frame sequencer, the image memory and the conv core.
// The master side drives start/hold/kernel_sel; the slave side (sequencer) drives everything else.
interface conv_frame_ctrl_if #(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 64,
   parameter int ADDRW  = 12,
   parameter int KSELW  = 2
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic             start;
   logic             hold;
   logic [KSELW-1:0] kernel_sel;
   logic             mem_rd_en;
   logic [ADDRW-1:0] mem_addr;
   logic             lb_shift;
   logic [KSELW-1:0] kern_sel_q;
   logic             out_valid;
   logic             out_zero;
   logic [XW-1:0]    out_x;
   logic [YW-1:0]    out_y;
   logic             out_last;
   logic             busy;
   logic             done;

   modport master (
      output start, hold, kernel_sel,
      input  mem_rd_en, mem_addr, lb_shift, kern_sel_q,
      input  out_valid, out_zero, out_x, out_y, out_last, busy, done
   );

   modport slave (
      input  start, hold, kernel_sel,
      output mem_rd_en, mem_addr, lb_shift, kern_sel_q,
      output out_valid, out_zero, out_x, out_y, out_last, busy, done
   );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Raster-order frame sequencer for the 3x3 convolution core: issues one memory read per
// cycle, shifts returned pixels into the line buffer and emits per-pixel output strobes.
module conv_frame_ctrl #(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 64,
   parameter int ADDRW  = 12,
   parameter int KSELW  = 2
) (
   input  logic               clk,
   input  logic               rst,
   conv_frame_ctrl_if.slave   bus
);
   localparam int N  = WIDTH * HEIGHT;
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int CW = ADDRW + 1;

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(N - 1);
   localparam logic [CW-1:0]    LAST_OUT  = CW'(N - 1);
   localparam logic [CW-1:0]    EMIT_LAG  = CW'(WIDTH + 1);
   localparam logic [XW-1:0]    X_MAX     = XW'(WIDTH - 1);
   localparam logic [YW-1:0]    Y_MAX     = YW'(HEIGHT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [ADDRW-1:0] rd_idx_q;
   logic [CW-1:0]    shift_cnt_q;
   logic [CW-1:0]    emit_cnt_q;
   logic [XW-1:0]    x_q;
   logic [YW-1:0]    y_q;
   logic [KSELW-1:0] kern_sel_q;
   logic             lb_shift_q;
   logic             out_valid_q;
   logic             out_zero_q;
   logic             out_last_q;
   logic [XW-1:0]    out_x_q;
   logic [YW-1:0]    out_y_q;
   logic             busy_q;
   logic             done_q;

   logic             rd_en_d;
   logic             shift_emit_d;
   logic             drain_tick_d;
   logic             emit_d;
   logic             border_d;
   logic             last_emit_d;
   logic [XW-1:0]    x_d;
   logic [YW-1:0]    y_d;

   always_comb begin
      rd_en_d      = (state_q == S_READ) && !bus.hold;
      // A window is complete once the pixel one row and one column past its centre has shifted in.
      shift_emit_d = lb_shift_q && (shift_cnt_q >= EMIT_LAG);
      // The trailing WIDTH+1 outputs are all border pixels, so they are emitted without data.
      drain_tick_d = (state_q == S_DRAIN) && !bus.hold && !lb_shift_q;
      emit_d       = shift_emit_d || drain_tick_d;
      border_d     = (x_q == '0) || (x_q == X_MAX) || (y_q == '0) || (y_q == Y_MAX);
      last_emit_d  = emit_d && (emit_cnt_q == LAST_OUT);
      x_d          = x_q;
      y_d          = y_q;
      if (x_q == X_MAX) begin
         x_d = '0;
         y_d = y_q + 1'b1;
      end else begin
         x_d = x_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_idx_q    <= '0;
         shift_cnt_q <= '0;
         emit_cnt_q  <= '0;
         x_q         <= '0;
         y_q         <= '0;
         kern_sel_q  <= '0;
         lb_shift_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_zero_q  <= 1'b0;
         out_last_q  <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         lb_shift_q  <= rd_en_d;
         out_valid_q <= emit_d;
         out_zero_q  <= emit_d && border_d;
         out_last_q  <= last_emit_d;
         done_q      <= 1'b0;
         if (rd_en_d) begin
            rd_idx_q <= rd_idx_q + 1'b1;
         end
         if (lb_shift_q) begin
            shift_cnt_q <= shift_cnt_q + 1'b1;
         end
         if (emit_d) begin
            out_x_q    <= x_q;
            out_y_q    <= y_q;
            emit_cnt_q <= emit_cnt_q + 1'b1;
            x_q        <= x_d;
            y_q        <= y_d;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  kern_sel_q  <= bus.kernel_sel;
                  rd_idx_q    <= '0;
                  shift_cnt_q <= '0;
                  emit_cnt_q  <= '0;
                  x_q         <= '0;
                  y_q         <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= S_READ;
               end
            end
            S_READ: begin
               if (rd_en_d && (rd_idx_q == LAST_ADDR)) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (last_emit_d) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_rd_en  = rd_en_d;
   assign bus.mem_addr   = (state_q == S_READ) ? rd_idx_q : '0;
   assign bus.lb_shift   = lb_shift_q;
   assign bus.kern_sel_q = kern_sel_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_zero   = out_zero_q;
   assign bus.out_x      = out_x_q;
   assign bus.out_y      = out_y_q;
   assign bus.out_last   = out_last_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Frame-level bench for conv_frame_ctrl: a schedule model derived from the hold trace
// predicts every read, shift, output strobe and done pulse cycle by cycle.
module tb_conv_frame_ctrl;
   localparam int WIDTH  = 64;
   localparam int HEIGHT = 64;
   localparam int ADDRW  = 12;
   localparam int KSELW  = 2;
   localparam int N      = WIDTH * HEIGHT;
   localparam int XW     = $clog2(WIDTH);
   localparam int YW     = $clog2(HEIGHT);
   localparam int MAXC   = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   bit   h     [MAXC];
   bit   e_rd  [MAXC];
   int   e_addr[MAXC];
   bit   e_sh  [MAXC];
   int   e_idx [MAXC];
   int   shift_cyc[N];
   int   out_cyc  [N];

   always #5 clk = ~clk;

   conv_frame_ctrl_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDRW(ADDRW), .KSELW(KSELW)) bus ();

   conv_frame_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDRW(ADDRW), .KSELW(KSELW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic report_summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
         if (failures >= 40) begin
            report_summary();
            $finish;
         end
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({bus.mem_rd_en, bus.mem_addr, bus.lb_shift, bus.kern_sel_q, bus.out_valid,
                  bus.out_zero, bus.out_x, bus.out_y, bus.out_last, bus.busy, bus.done});
   endfunction

   // mode 0: no hold, 1: hold 500..509, 2: hold 5 cycles in drain,
   // 3: random hold plus junk start/kernel_sel, 4: reset at cycle 1000
   task automatic run_frame(input int mode);
      int rd_cnt, c, done_c, first_v, last_v, done_seen, nvalid, nzero, c11, z11, k;
      logic [KSELW-1:0] ks;
      logic [ADDRW-1:0] ea, ga;
      logic [XW-1:0]    ex, gx;
      logic [YW-1:0]    ey, gy;
      logic             ez, el, gz, gl, eb, gb;
      logic [63:0]      got, exp;

      for (int i = 0; i < MAXC; i++) begin
         e_rd[i] = 0; e_addr[i] = 0; e_sh[i] = 0; e_idx[i] = -1;
         case (mode)
            1:       h[i] = (i >= 500) && (i <= 509);
            2:       h[i] = (i >= 4110) && (i <= 4114);
            3:       h[i] = (i < 7000) && ($urandom_range(0, 15) == 0);
            default: h[i] = 0;
         endcase
      end

      // Reads fill the first N unheld cycles; data shifts the cycle after.
      rd_cnt = 0;
      for (int cc = 1; rd_cnt < N; cc++) begin
         if (!h[cc]) begin
            e_rd[cc] = 1; e_addr[cc] = rd_cnt;
            shift_cyc[rd_cnt] = cc + 1; e_sh[cc + 1] = 1;
            rd_cnt++;
         end
      end
      for (int j = 0; j < N - WIDTH - 1; j++) out_cyc[j] = shift_cyc[j + WIDTH + 1] + 1;
      c = shift_cyc[N - 1] + 1;
      for (int j = N - WIDTH - 1; j < N; j++) begin
         while (h[c]) c++;
         out_cyc[j] = c + 1;
         c++;
      end
      for (int j = 0; j < N; j++) e_idx[out_cyc[j]] = j;
      done_c = out_cyc[N - 1] + 1;

      ks = KSELW'($urandom_range(0, (1 << KSELW) - 1));
      first_v = -1; last_v = -1; done_seen = -1; nvalid = 0; nzero = 0; c11 = -1; z11 = -1;

      @(negedge clk);
      bus.start = 1'b1;
      bus.kernel_sel = ks;
      bus.hold = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;

      for (c = 1; c <= done_c + 1; c++) begin
         bus.hold = h[c];
         if (mode == 3 && c < done_c) begin
            bus.start = ($urandom_range(0, 31) == 0);
            bus.kernel_sel = KSELW'($urandom_range(0, (1 << KSELW) - 1));
         end else begin
            bus.start = 1'b0;
         end
         if (mode == 4 && c == 1000) begin
            #1 rst = 1'b1;
            @(negedge clk);
            check_val("rst_mid_frame_outputs", all_outputs(), 64'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            bus.hold = 1'b0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               check_val("post_rst_idle", 64'({bus.done, bus.busy, bus.out_valid, bus.mem_rd_en}), 64'd0);
            end
            $display("frame mode=%0d kern=%0d aborted by reset at cycle 1000", mode, ks);
            return;
         end
         @(negedge clk);

         k = e_idx[c];
         ea = e_rd[c] ? ADDRW'(e_addr[c]) : ADDRW'(0);
         ga = e_rd[c] ? bus.mem_addr : ADDRW'(0);
         if (k >= 0) begin
            ex = XW'(k % WIDTH); ey = YW'(k / WIDTH);
            ez = (k % WIDTH == 0) || (k % WIDTH == WIDTH - 1) || (k / WIDTH == 0) || (k / WIDTH == HEIGHT - 1);
            el = (k == N - 1);
            gx = bus.out_x; gy = bus.out_y; gz = bus.out_zero; gl = bus.out_last;
         end else begin
            ex = '0; ey = '0; ez = 1'b0; el = 1'b0;
            gx = '0; gy = '0; gz = 1'b0; gl = 1'b0;
         end
         eb = (c < done_c);
         gb = (c == done_c) ? 1'b0 : bus.busy;
         exp = 64'({e_rd[c], ea, e_sh[c], (k >= 0), ex, ey, ez, el, (c == done_c), eb, ks});
         got = 64'({bus.mem_rd_en, ga, bus.lb_shift, bus.out_valid, gx, gy, gz, gl, bus.done, gb, bus.kern_sel_q});
         check_val($sformatf("mode%0d_cyc%0d", mode, c), got, exp);

         if (bus.out_valid) begin
            nvalid++;
            if (first_v < 0) first_v = c;
            if (bus.out_zero) nzero++;
            if (bus.out_last) last_v = c;
            if (bus.out_x == XW'(1) && bus.out_y == YW'(1)) begin
               c11 = c; z11 = int'(bus.out_zero);
            end
         end
         if (bus.done && done_seen < 0) done_seen = c;
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.hold = 1'b0;

      check_val("n_valid", 64'(nvalid), 64'(N));
      check_val("n_border", 64'(nzero), 64'd252);
      check_val("done_cycle_model", 64'(done_seen), 64'(done_c));
      if (mode == 0) begin
         check_val("first_valid_cycle", 64'(first_v), 64'd68);
         check_val("pix11_cycle", 64'(c11), 64'd133);
         check_val("pix11_zero", 64'(z11), 64'd0);
         check_val("last_cycle", 64'(last_v), 64'd4163);
         check_val("done_cycle", 64'(done_seen), 64'd4164);
      end else if (mode == 1) begin
         check_val("done_cycle_hold_read", 64'(done_seen), 64'd4174);
      end else if (mode == 2) begin
         check_val("last_cycle_hold_drain", 64'(last_v), 64'd4168);
         check_val("done_cycle_hold_drain", 64'(done_seen), 64'd4169);
      end
      $display("frame mode=%0d kern=%0d outputs=%0d border=%0d done_cycle=%0d", mode, ks, nvalid, nzero, done_seen);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.hold = 1'b0;
      bus.kernel_sel = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_outputs", all_outputs(), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_outputs", all_outputs(), 64'd0);
      run_frame(0);
      run_frame(1);
      run_frame(2);
      run_frame(3);
      run_frame(4);
      run_frame(0);
      report_summary();
      $finish;
   end

   initial begin
      #3000000;
      failures++;
      $display("FAIL watchdog got=timeout expected=finish");
      report_summary();
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the 3x3 convolution datapath. On a start pulse it scans one WIDTH x HEIGHT image memory in raster order, one read per cycle, and drives the pixel shift into the line-buffered convolution core. It emits one output strobe per output pixel with its coordinates and a border-zero flag, and latches the kernel selection for the whole frame. It sits between the image memory or host and the conv core, replacing the nested software loops used in behavioural benches.

## Interface
- WIDTH, 64, pixels per row (>= 3)
- HEIGHT, 64, rows per frame (>= 3)
- ADDRW, 12, memory address width, >= clog2(WIDTH*HEIGHT)
- KSELW, 2, kernel-select width
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame start pulse; sampled only in IDLE
- hold  in  1  issue-side stall; freezes new reads and drain ticks
- kernel_sel  in  KSELW  kernel choice, latched on accepted start
- mem_rd_en  out  1  memory read strobe; read latency is exactly 1 cycle
- mem_addr  out  ADDRW  read address = r*WIDTH + c
- lb_shift  out  1  memory data valid this cycle; shift it into the line buffer
- kern_sel_q  out  KSELW  latched kernel select to the core
- out_valid  out  1  one output pixel this cycle, aligned with the core's registered result
- out_zero  out  1  output pixel is on the frame border; core output is forced to 0
- out_x  out  clog2(WIDTH)  output column
- out_y  out  clog2(HEIGHT)  output row
- out_last  out  1  with out_valid, marks the final pixel (HEIGHT-1, WIDTH-1)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last output

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: when start=1, latch kernel_sel into kern_sel_q, clear all counters and go to READ. busy=1 from the next cycle.
- READ: mem_rd_en = !hold. mem_addr = rd_idx. rd_idx increments on each read.
  - After the read with rd_idx = N-1 (N = WIDTH*HEIGHT), go to DRAIN.
- lb_shift is mem_rd_en delayed by one cycle and is never suppressed by hold. In-flight data always shifts.
- Shift counter s counts lb_shift cycles from 0. An lb_shift with s >= WIDTH+1 generates an emit for output index o = s-(WIDTH+1). The window centred on o is complete once pixel o+WIDTH+1 has shifted in.
- DRAIN: tick = !hold && !lb_shift. Each tick generates an emit for the next output index.
  - After the emit for index N-1, go to DONE.
  - The WIDTH+1 drained outputs are all border pixels, so they need no window.
- DONE: done=1 for one cycle, busy=0 from the next cycle, then return to IDLE.
- Emit pipeline: out_valid, out_x, out_y, out_zero and out_last are registered. They appear the cycle after the emit.
  - out_zero = (y==0 || y==HEIGHT-1 || x==0 || x==WIDTH-1).
  - out_x and out_y advance in raster order: x wraps at WIDTH-1 and increments y.
- start while busy is ignored, and kernel_sel changes mid-frame are ignored.
- Output order is strict raster order, with exactly N out_valid pulses per frame.

## Timing
- Reset values: every output is 0, the state is IDLE and all counters are 0. Reset mid-frame aborts immediately, with no done pulse.
- Cycle numbering below uses start accepted at edge 0 and hold=0 throughout:
  - mem_rd_en is high in cycles 1..N.
  - lb_shift is high in cycles 2..N+1.
  - out_valid is high in cycles WIDTH+4 .. N+WIDTH+3, continuously.
  - done is high in cycle N+WIDTH+4.
- Total frame latency is N+WIDTH+4 cycles.
- hold raised in cycle t:
  - No mem_rd_en in cycle t.
  - At most one further lb_shift/out_valid pair, the one already in flight.
  - Every later output is delayed by exactly the number of hold cycles.
- hold in DRAIN pauses ticks only.
- hold in IDLE or DONE has no effect.
- start and rst asserted together: rst wins.

## Test plan
- WIDTH=HEIGHT=64, no hold, start at edge 0:
  - mem_addr is 0..4095 in cycles 1..4096.
  - First out_valid is in cycle 68 at (0,0) with out_zero=1.
  - 4096 contiguous out_valid pulses follow.
  - out_last is in cycle 4163 at (63,63), and done is in cycle 4164.
- Same run, check interior alignment:
  - The out_valid at (1,1) is in cycle 133 with out_zero=0.
  - It coincides with the core result for the window rows 0..2, cols 0..2.
  - out_zero=1 exactly for the 252 border pixels.
- hold=1 for cycles 500..509:
  - No mem_rd_en in those cycles.
  - Exactly one lb_shift, in cycle 500.
  - done moves to cycle 4174, and the output sequence is unchanged.
- hold=1 for 5 cycles inside DRAIN: out_last and done shift by 5, and the 65 drained outputs all have out_zero=1.
- kernel_sel changes and extra start pulses mid-frame:
  - kern_sel_q keeps the value latched at start.
  - No restart occurs, and the counts are unchanged.
- rst pulsed in cycle 1000:
  - All outputs read 0 within the same cycle, with no done pulse.
  - A subsequent start gives a full, correct 4096-pixel frame.
